// File: rtl/mem_req_ctrl_pkg.sv
// Shared encodings for the load/store front end: funct3 width codes, MemWrite
// store-size codes, FSM states and small request-decode helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_B    = 2'b01;
  localparam logic [1:0] MW_H    = 2'b10;
  localparam logic [1:0] MW_W    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Illegal width code or an address not aligned to the access size.
  function automatic logic req_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] mw_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return MW_B;
      2'b01:   return MW_H;
      default: return MW_W;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Bundle of the core-side request/response signals and the memory_com-side
// levels; slave is the controller's view, master the environment's.
interface mem_req_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        write_enable;
  logic        read_enable;
  logic        mem_done;
  logic [31:0] address;
  logic [2:0]  SizeLoad;
  logic [1:0]  MemWrite;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata, mem_done, readData,
    input  cpu_stall, cpu_resp_valid, cpu_rdata, cpu_err,
    input  write_enable, read_enable, address, SizeLoad, MemWrite, writeData
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata, mem_done, readData,
    output cpu_stall, cpu_resp_valid, cpu_rdata, cpu_err,
    output write_enable, read_enable, address, SizeLoad, MemWrite, writeData
  );
endinterface

// File: rtl/mem_req_ctrl_load_extend.sv
// Selects the addressed byte/half lane of a returned word and sign- or
// zero-extends it according to the RV32 load width code.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b [4];
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_b[gi] = word[8*gi +: 8];
  end

  assign sel_b = lane_b[addr_lo];
  assign sel_h = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    case (funct3)
      F3_B:    result = {{24{sel_b[7]}}, sel_b};
      F3_BU:   result = {24'd0, sel_b};
      F3_H:    result = {{16{sel_h[15]}}, sel_h};
      F3_HU:   result = {16'd0, sel_h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Load/store front end for memory_com: checks alignment, holds the request
// levels until mem_done, stalls the core, returns extended load data.
// Optional BUSY watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_req_ctrl_if.slave  bus
);

  state_t      state_reg, state_next;
  logic        we_reg;
  logic        req_fire, req_err, done_fire, timeout_hit;
  logic [31:0] ext_word;

  assign req_fire  = (state_reg == ST_IDLE) && bus.cpu_req;
  assign req_err   = req_bad(bus.cpu_funct3, bus.cpu_addr[1:0]);
  assign done_fire = (state_reg == ST_BUSY) && bus.mem_done;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg;

  // Held at zero outside BUSY, so it starts from zero on every BUSY entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  cnt_reg <= '0;
    else if (state_reg != ST_BUSY) cnt_reg <= '0;
    else                           cnt_reg <= cnt_reg + 1'b1;
  end

  assign timeout_hit = (state_reg == ST_BUSY) && !bus.mem_done &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  load_extend u_load_extend (
    .word    (bus.readData),
    .addr_lo (bus.address[1:0]),
    .funct3  (bus.SizeLoad),
    .result  (ext_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_fire) state_next = req_err ? ST_RESP : ST_BUSY;
      ST_BUSY: if (done_fire || timeout_hit) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_stall = req_fire || (state_reg == ST_BUSY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.write_enable   <= 1'b0;
      bus.read_enable    <= 1'b0;
      bus.cpu_resp_valid <= 1'b0;
      bus.cpu_err        <= 1'b0;
      bus.cpu_rdata      <= '0;
      bus.address        <= '0;
      bus.SizeLoad       <= '0;
      bus.MemWrite       <= MW_NONE;
      bus.writeData      <= '0;
      we_reg             <= 1'b0;
    end else begin
      bus.cpu_resp_valid <= (state_next == ST_RESP);
      if (req_fire) begin
        bus.address      <= bus.cpu_addr;
        bus.SizeLoad     <= bus.cpu_funct3;
        bus.MemWrite     <= bus.cpu_we ? mw_of(bus.cpu_funct3) : MW_NONE;
        bus.writeData    <= replicate(bus.cpu_funct3, bus.cpu_wdata);
        bus.write_enable <= !req_err && bus.cpu_we;
        bus.read_enable  <= !req_err && !bus.cpu_we;
        bus.cpu_err      <= req_err;
        we_reg           <= bus.cpu_we;
      end
      // timeout_hit already excludes mem_done, so a coincident mem_done wins.
      if (done_fire || timeout_hit) begin
        bus.write_enable <= 1'b0;
        bus.read_enable  <= 1'b0;
        bus.cpu_err      <= timeout_hit;
        if (done_fire && !we_reg) bus.cpu_rdata <= ext_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed steps followed by random
// load/store requests compared against an arithmetic reference model.
module tb_mem_req_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] model_rdata = 32'd0;

  mem_req_ctrl_if bus();

  mem_req_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, 0 for an illegal width code.
  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    if (f3 == 3'd2) return 4;
    return 0;
  endfunction

  function automatic bit m_err(input logic [2:0] f3, input logic [31:0] addr);
    int sz = m_size(f3);
    return (sz == 0) || ((addr % sz) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] v;
    int sz = m_size(f3);
    v = word >> (8 * (addr % 4));
    if (sz == 4) return word;
    if (sz == 1) begin
      v = v % 256;
      if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
    end else begin
      v = v % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    int sz = m_size(f3);
    if (sz == 1) return (wdata % 256) * 32'h01010101;
    if (sz == 2) return (wdata % 65536) * 32'h00010001;
    return wdata;
  endfunction

  function automatic logic [31:0] m_mw(input logic [2:0] f3);
    int sz = m_size(f3);
    return (sz == 1) ? 32'd1 : (sz == 2) ? 32'd2 : 32'd3;
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay, input logic [31:0] word,
                        input bit timeout);
    bit err;
    int cycles;
    err = m_err(f3, addr);
    cycles = timeout ? 16 : delay + 1;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_funct3 = f3;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    #1 check("stall_req", bus.cpu_stall, 1);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    if (err) begin
      check("err_re", bus.read_enable, 0);
      check("err_we", bus.write_enable, 0);
      check("err_rv", bus.cpu_resp_valid, 1);
      check("err_err", bus.cpu_err, 1);
      check("err_rdata", bus.cpu_rdata, model_rdata);
      check("err_stall", bus.cpu_stall, 0);
    end else begin
      for (int i = 0; i < cycles; i++) begin
        if (i > 0) @(negedge clk);
        check("busy_re", bus.read_enable, !we);
        check("busy_we", bus.write_enable, we);
        check("busy_stall", bus.cpu_stall, 1);
        check("busy_rv", bus.cpu_resp_valid, 0);
        if (i == 0) begin
          check("addr", bus.address, addr);
          check("sizeload", bus.SizeLoad, f3);
          check("memwrite", bus.MemWrite, we ? m_mw(f3) : 32'd0);
          if (we) check("wdata", bus.writeData, m_wdata(f3, wdata));
        end
      end
      if (!timeout) begin
        bus.mem_done = 1'b1;
        bus.readData = word;
      end
      @(negedge clk);
      bus.mem_done = 1'b0;
      bus.readData = $urandom;
      if (!timeout && !we) model_rdata = m_load(f3, addr, word);
      check("resp_re", bus.read_enable, 0);
      check("resp_we", bus.write_enable, 0);
      check("resp_rv", bus.cpu_resp_valid, 1);
      check("resp_err", bus.cpu_err, timeout);
      check("resp_rdata", bus.cpu_rdata, model_rdata);
      check("resp_stall", bus.cpu_stall, 0);
    end
    @(negedge clk);
    check("idle_rv", bus.cpu_resp_valid, 0);
  endtask

  // Protocol monitor: the bench must only raise cpu_req while the block is idle.
  always begin
    @(negedge clk);
    #2;
    if (bus.cpu_req) begin
      n_assert++;
      assert (!(bus.read_enable || bus.write_enable || bus.cpu_resp_valid)) else begin
        n_fail++;
        $error("FAIL req_while_busy: observed busy 1 expected 0");
      end
    end
  end

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'd0;
    bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
    bus.mem_done = 1'b0; bus.readData = 32'd0;

    repeat (2) @(negedge clk);
    check("rst_re", bus.read_enable, 0);
    check("rst_we", bus.write_enable, 0);
    check("rst_rv", bus.cpu_resp_valid, 0);
    check("rst_err", bus.cpu_err, 0);
    check("rst_rdata", bus.cpu_rdata, 0);
    check("rst_addr", bus.address, 0);
    check("rst_sizeload", bus.SizeLoad, 0);
    check("rst_memwrite", bus.MemWrite, 0);
    check("rst_wdata", bus.writeData, 0);
    check("rst_stall", bus.cpu_stall, 0);
    reset_n = 1'b1;

    do_req(1'b0, F3_B,  32'h0000_1003, 32'd0, 3, 32'h80FF_1234, 1'b0);
    check("lb_value", model_rdata, 32'hFFFF_FF80);
    do_req(1'b0, F3_HU, 32'h0000_2002, 32'd0, 2, 32'hBEEF_0000, 1'b0);
    check("lhu_value", model_rdata, 32'h0000_BEEF);
    do_req(1'b1, F3_B,  32'h0000_0010, 32'h1234_56A5, 40, 32'd0, 1'b0);
    do_req(1'b0, F3_W,  32'h0000_0006, 32'd0, 0, 32'd0, 1'b0);

    // mem_done while idle must be ignored
    @(negedge clk);
    bus.mem_done = 1'b1; bus.readData = 32'h1111_2222;
    @(negedge clk);
    bus.mem_done = 1'b0;
    check("idle_done_rv", bus.cpu_resp_valid, 0);
    check("idle_done_rdata", bus.cpu_rdata, model_rdata);
    check("idle_done_re", bus.read_enable, 0);

    // async reset in the middle of a load
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_funct3 = F3_W; bus.cpu_addr = 32'h20;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    check("pre_rst_re", bus.read_enable, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_re", bus.read_enable, 0);
    check("mid_rst_we", bus.write_enable, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_rdata = 32'd0;
    check("post_rst_rdata", bus.cpu_rdata, 0);
    check("post_rst_rv", bus.cpu_resp_valid, 0);
    do_req(1'b1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 1, 32'd0, 1'b0);

`ifdef MEM_TIMEOUT_EN
    do_req(1'b0, F3_B, 32'h0000_0040, 32'd0, 0, 32'd0, 1'b1);
`endif

    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             int'($urandom_range(0, 5)), $urandom, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
